// File: rtl/axis_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_uart_pkg
// Description : Shared constants, FSM state type and frame-size helper for the
//               AXI-Stream UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_t;

    // Serial bits per frame: start + data + optional parity + stop bits.
    function automatic int frame_bits(input int data_w, input int parity, input int stop_bits);
        return 1 + data_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axis_uart_sync_fifo
// Description : Single-clock FIFO with registered occupancy; push on full and
//               pop on empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_uart_sync_fifo
    import axis_uart_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] LEVEL_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   level_q;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (level_q == LEVEL_FULL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    // Storage is left unreset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (w_push && !w_pop) begin
                level_q <= level_q + 1'b1;
            end else if (!w_push && w_pop) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axis_uart_tx_fifo
// Description : AXI-Stream slave feeding a FIFO-buffered UART transmitter with
//               configurable data width, parity, stop bits and bit period.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_uart_tx_fifo
    import axis_uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    output logic                        s_axis_tready,
    output logic                        uart_tx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        pkt_done
);

    localparam int TMR_W      = $clog2(CLKS_PER_BIT);
    localparam int FRAME_BITS = frame_bits(DATA_W, PARITY, STOP_BITS);
    localparam int IDX_W      = $clog2(FRAME_BITS);
    localparam logic [TMR_W-1:0] TMR_RELOAD    = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(DATA_W);
    localparam logic [IDX_W-1:0] IDX_LAST_STOP = IDX_W'(FRAME_BITS - 1);

    tx_state_t         state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              last_q, last_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              ready_en_q;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_bit_end;
    logic [DATA_W:0]   w_head;

    assign s_axis_tready = ready_en_q && !w_full;
    assign w_push        = s_axis_tvalid && s_axis_tready;
    assign uart_tx       = tx_q;
    assign pkt_done      = done_q;
    assign tx_busy       = (state_q != ST_IDLE) || (fifo_level != '0);
    assign w_bit_end     = (tmr_q == '0);

    axis_uart_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .wdata_i ({s_axis_tlast, s_axis_tdata}),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (fifo_level)
    );

    // idx_q counts serial bits across the whole frame: 0 is the start bit.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        last_d  = last_q;
        done_d  = 1'b0;
        w_pop   = 1'b0;

        if (state_q != ST_IDLE) begin
            tmr_d = w_bit_end ? TMR_RELOAD : tmr_q - 1'b1;
            if (w_bit_end) begin
                idx_d = idx_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    shift_d = w_head[DATA_W-1:0];
                    last_d  = w_head[DATA_W];
                    par_d   = (PARITY == PAR_ODD) ? ~^w_head[DATA_W-1:0] : ^w_head[DATA_W-1:0];
                    tmr_d   = TMR_RELOAD;
                    idx_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST_DATA) begin
                        state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    end
                end
            end
            ST_PAR: begin
                if (w_bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_end && (idx_q == IDX_LAST_STOP)) begin
                    state_d = ST_IDLE;
                    done_d  = last_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line level follows the next state so uart_tx comes straight from a flop.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            ST_PAR:   tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            last_q     <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            last_q     <= last_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            ready_en_q <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_uart_tx_fifo
// Description : Four frame-format configurations driven with directed and
//               random AXIS traffic, checked cycle by cycle against a
//               queue-based line model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int NCFG  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input int cfg, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL cfg%0d %s: got 0x%0h expected 0x%0h", cfg, name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int DW    = (g == 3) ? 5 : 8;
        localparam int PAR   = (g == 0) ? 2 : (g == 1) ? 1 : 0;
        localparam int STB   = (g == 1) ? 2 : 1;
        localparam int NBITS = 1 + DW + ((PAR != 0) ? 1 : 0) + STB;
        localparam int LVL_W = $clog2(DEPTH) + 1;
        // Hand-derived frames: bit i of LIT_BITS is serial bit i (start = bit 0).
        localparam int          LIT_D    = (g == 0) ? 'hA5 : (g == 1) ? 'h07 : (g == 2) ? 'h3C : 'h1F;
        localparam logic [11:0] LIT_BITS = (g == 0) ? 12'hD4A : (g == 1) ? 12'hC0E : (g == 2) ? 12'hE78 : 12'hFFE;
        localparam int          LIT_LEN  = (g == 0) ? 44 : (g == 1) ? 48 : (g == 2) ? 40 : 28;

        logic             rst    = 1'b0;
        logic             tvalid = 1'b0;
        logic             tlast  = 1'b0;
        logic [DW-1:0]    tdata  = '0;
        logic             tready;
        logic             tx;
        logic             busy;
        logic             pkt;
        logic [LVL_W-1:0] level;
        bit               done_b = 1'b0;

        axis_uart_tx_fifo #(
            .DATA_W       (DW),
            .FIFO_DEPTH   (DEPTH),
            .CLKS_PER_BIT (CPB),
            .PARITY       (PAR),
            .STOP_BITS    (STB)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .s_axis_tdata  (tdata),
            .s_axis_tvalid (tvalid),
            .s_axis_tlast  (tlast),
            .s_axis_tready (tready),
            .uart_tx       (tx),
            .tx_busy       (busy),
            .fifo_level    (level),
            .pkt_done      (pkt)
        );

        // Line model: queued beats, current frame as a bit list, one idle cycle between frames.
        int  m_qd[$];
        bit  m_ql[$];
        bit  ebits[12];
        bit  m_en   = 1'b0;
        bit  m_busy = 1'b0;
        bit  m_last = 1'b0;
        bit  m_pkt  = 1'b0;
        int  m_k    = 0;

        always @(posedge clk or negedge rst) begin : p_model
            int d;
            int ones;
            bit acc;
            if (!rst) begin
                m_qd.delete();
                m_ql.delete();
                m_en   = 1'b0;
                m_busy = 1'b0;
                m_pkt  = 1'b0;
                m_k    = 0;
            end else begin
                acc   = tvalid && m_en && (m_qd.size() < DEPTH);
                m_pkt = 1'b0;
                if (m_busy) begin
                    m_k++;
                    if (m_k == NBITS * CPB) begin
                        m_busy = 1'b0;
                        m_pkt  = m_last;
                    end
                end else if (m_qd.size() != 0) begin
                    d      = m_qd.pop_front();
                    m_last = m_ql.pop_front();
                    ones   = 0;
                    ebits[0] = 1'b0;
                    for (int i = 0; i < DW; i++) begin
                        ebits[1 + i] = d[i];
                        ones += int'(d[i]);
                    end
                    if (PAR != 0) ebits[1 + DW] = (PAR == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
                    for (int i = NBITS - STB; i < NBITS; i++) ebits[i] = 1'b1;
                    m_busy = 1'b1;
                    m_k    = 0;
                end
                if (acc) begin
                    m_qd.push_back(int'(tdata));
                    m_ql.push_back(tlast);
                end
                m_en = 1'b1;
            end
        end

        always @(negedge clk) begin : p_compare
            logic [LVL_W+3:0] exp_v;
            logic [LVL_W+3:0] act_v;
            exp_v = {(m_busy ? ebits[m_k / CPB] : 1'b1),
                     (m_en && (m_qd.size() < DEPTH)),
                     (m_busy || (m_qd.size() != 0)),
                     m_pkt,
                     LVL_W'(m_qd.size())};
            act_v = {tx, tready, busy, pkt, level};
            check(g, "outputs{tx,rdy,busy,pkt,lvl}", 32'(act_v), 32'(exp_v));
        end

        task automatic send(input int d, input bit l);
            bit ok;
            ok     = 1'b0;
            tvalid = 1'b1;
            tdata  = DW'(d);
            tlast  = l;
            for (int t = 0; t < 2000 && !ok; t++) begin
                @(negedge clk);
                ok = tready;
                @(posedge clk);
                #1;
            end
            tvalid = 1'b0;
            tlast  = 1'b0;
            check(g, "beat accepted", 32'(ok), 32'd1);
        endtask

        task automatic reset_pulse();
            repeat (3) @(posedge clk);
            #2 rst = 1'b1;
            @(negedge clk);
            check(g, "tready low before first edge", 32'(tready), 32'd0);
            @(negedge clk);
            check(g, "tready high after first edge", 32'(tready), 32'd1);
        endtask

        task automatic capture(output logic [11:0] bits, output int len);
            bits = '1;
            len  = -1;
            for (int t = 0; t < 100 && tx !== 1'b0; t++) @(negedge clk);
            for (int c = 0; c < 200; c++) begin
                if ((c % CPB == 1) && (c / CPB < 12)) bits[c / CPB] = tx;
                if (pkt === 1'b1) begin
                    len = c;
                    break;
                end
                @(negedge clk);
            end
        endtask

        initial begin : p_stim
            logic [11:0] bits;
            int          len;
            int          lows;

            reset_pulse();

            // Single hand-computed frame.
            @(posedge clk);
            #1;
            send(LIT_D, 1'b1);
            capture(bits, len);
            check(g, "literal frame bits", 32'(bits), 32'(LIT_BITS));
            check(g, "literal frame length", 32'(len), 32'(LIT_LEN));
            @(negedge clk);
            check(g, "busy low after frame", 32'(busy), 32'd0);

            // Ten beats with tvalid held: backpressure, spacing, single pkt_done.
            @(posedge clk);
            #1;
            fork
                for (int i = 0; i < 10; i++) send(i, i == 9);
                begin : burst_mon
                    int c0;
                    int npk;
                    int mx;
                    c0  = -1;
                    npk = 0;
                    mx  = 0;
                    for (int c = 0; c < 700; c++) begin
                        @(negedge clk);
                        if (c0 < 0 && tx === 1'b0) c0 = c;
                        if (c0 >= 0 && c == c0 + LIT_LEN)     check(g, "burst idle gap", 32'(tx), 32'd1);
                        if (c0 >= 0 && c == c0 + LIT_LEN + 1) check(g, "burst next start", 32'(tx), 32'd0);
                        if (int'(level) > mx) mx = int'(level);
                        if (pkt === 1'b1) npk++;
                    end
                    check(g, "burst pkt_done count", 32'(npk), 32'd1);
                    check(g, "burst peak level", 32'(mx), 32'(DEPTH));
                end
            join

            // Reset in the middle of an all-zero frame.
            send(0, 1'b0);
            send(0, 1'b0);
            send(0, 1'b1);
            repeat (10) @(negedge clk);
            check(g, "tx low mid-frame", 32'(tx), 32'd0);
            #2 rst = 1'b0;
            #1;
            check(g, "reset tx high", 32'(tx), 32'd1);
            check(g, "reset level", 32'(level), 32'd0);
            check(g, "reset tready", 32'(tready), 32'd0);
            check(g, "reset pkt_done", 32'(pkt), 32'd0);
            reset_pulse();
            lows = 0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                if (tx !== 1'b1) lows++;
            end
            check(g, "no residual frame", 32'(lows), 32'd0);

            // Random traffic with random gaps.
            @(posedge clk);
            #1;
            for (int i = 0; i < 30; i++) begin
                send(int'($urandom_range(0, (1 << DW) - 1)), $urandom_range(0, 3) == 0);
                repeat ($urandom_range(0, 50)) @(posedge clk);
                #1;
            end
            for (int t = 0; t < 3000 && busy !== 1'b0; t++) @(negedge clk);
            check(g, "drained busy", 32'(busy), 32'd0);
            done_b = 1'b1;
        end
    end

    initial begin : p_main
        bit all_done;
        all_done = 1'b0;
        for (int t = 0; t < 40000 && !all_done; t++) begin
            @(posedge clk);
            all_done = g_cfg[0].done_b && g_cfg[1].done_b && g_cfg[2].done_b && g_cfg[3].done_b;
        end
        check(0, "all configs finished", 32'(all_done), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
